// File: rtl/fortaegis_pkg.sv
// Shared constants and CRC step for the Fortaegis signature collector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fortaegis_pkg;

   localparam int SIG_W          = 32;
   localparam int CNT_W          = 16;
   localparam int COLLECT_CYCLES = 256;
   localparam int REP_LIMIT      = 32;

   localparam logic [SIG_W-1:0] POLY = 32'h04C11DB7;
   localparam logic [SIG_W-1:0] SEED = 32'hFFFFFFFF;

   // One MSB-first CRC shift: feedback is the outgoing MSB xor the new bit.
   function automatic logic [SIG_W-1:0] crc_step(input logic [SIG_W-1:0] s,
                                                 input logic             b,
                                                 input logic [SIG_W-1:0] poly);
      logic w_fb;
      w_fb = s[SIG_W-1] ^ b;
      return {s[SIG_W-2:0], 1'b0} ^ (w_fb ? poly : '0);
   endfunction

endpackage

// File: rtl/fortaegis_sig.sv
// CRC signature register: seed load, enable-gated fold of one bit per cycle.
// Latency: bit sampled at edge N is in o_sig after edge N.
// Backpressure: none; i_en gates every update.
module fortaegis_sig
   import fortaegis_pkg::*;
#(
   parameter logic [SIG_W-1:0] P_POLY = POLY,
   parameter logic [SIG_W-1:0] P_SEED = SEED
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_seed_ld,
   input  logic             i_en,
   input  logic             i_din,
   output logic [SIG_W-1:0] o_sig
);

   logic [SIG_W-1:0] r_sig;

   // Seed on reset or restart, otherwise fold din while enabled and hold when not.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_seed_ld) begin
         r_sig <= P_SEED;
      end else if (i_en) begin
         r_sig <= crc_step(r_sig, i_din, P_POLY);
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/frotaegis_top.sv
// Entropy/signature window: CRC + sample/ones counters while Collect is high, done pulse after it falls.
// Latency: sample at edge N visible after edge N; done one cycle after Collect reads low.
// Backpressure: none; restart is only honoured while Collect is low. Health test under FORTAEGIS_HEALTH_TEST_EN.
module frotaegis_top
   import fortaegis_pkg::*;
#(
   parameter int               COLLECT_CYCLES_P = COLLECT_CYCLES,
   parameter logic [SIG_W-1:0] P_POLY           = POLY,
   parameter logic [SIG_W-1:0] P_SEED           = SEED
) (
   input  logic             clk350,
   input  logic             rst,
   input  logic             din,
   input  logic             restart,
   output logic             collect,
   output logic [SIG_W-1:0] sig,
   output logic [CNT_W-1:0] samples,
   output logic [CNT_W-1:0] ones,
   output logic             done,
   output logic             health_fail
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(COLLECT_CYCLES_P - 1);

   // Collect is a plain register so it can be pulled low from outside to end a window early.
   logic             r_collect;
   logic             r_collect_d;
   logic             r_done;
   logic [CNT_W-1:0] r_samples;
   logic [CNT_W-1:0] r_ones;

   logic w_seed_ld;
   logic w_last;
   logic w_collect_nxt;

   assign w_seed_ld = ~r_collect & restart;
   assign w_last    = r_collect & (r_samples == LAST);

   // Next Collect: restart reopens, the final sample closes, otherwise hold.
   always_comb begin
      w_collect_nxt = r_collect;
      if (w_seed_ld) begin
         w_collect_nxt = 1'b1;
      end else if (w_last) begin
         w_collect_nxt = 1'b0;
      end
   end

   // Window flag, falling-edge done detect and the two counters.
   always_ff @(posedge clk350) begin
      if (rst) begin
         r_collect   <= 1'b1;
         r_collect_d <= 1'b1;
         r_done      <= 1'b0;
         r_samples   <= '0;
         r_ones      <= '0;
      end else begin
         r_collect   <= w_collect_nxt;
         r_collect_d <= r_collect;
         r_done      <= r_collect_d & ~r_collect;
         if (w_seed_ld) begin
            r_samples <= '0;
            r_ones    <= '0;
         end else if (r_collect) begin
            r_samples <= r_samples + 1'b1;
            r_ones    <= r_ones + {{(CNT_W-1){1'b0}}, din};
         end
      end
   end

   fortaegis_sig #(
      .P_POLY (P_POLY),
      .P_SEED (P_SEED)
   ) u_sig (
      .i_clk     (clk350),
      .i_rst     (rst),
      .i_seed_ld (w_seed_ld),
      .i_en      (r_collect),
      .i_din     (din),
      .o_sig     (sig)
   );

`ifdef FORTAEGIS_HEALTH_TEST_EN
   localparam logic [CNT_W-1:0] REP = CNT_W'(REP_LIMIT);

   logic             r_health_fail;
   logic [CNT_W-1:0] r_run;
   logic             r_last_bit;
   logic [CNT_W-1:0] w_run_nxt;

   // Run length including the current sample; the first sample of a window starts a fresh run.
   always_comb begin
      w_run_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
      if ((r_samples != '0) && (din == r_last_bit)) begin
         w_run_nxt = (r_run == REP) ? r_run : r_run + 1'b1;
      end
   end

   // Sticky repetition-count failure; cleared only by reset or an accepted restart.
   always_ff @(posedge clk350) begin
      if (rst) begin
         r_health_fail <= 1'b0;
         r_run         <= '0;
         r_last_bit    <= 1'b0;
      end else if (w_seed_ld) begin
         r_health_fail <= 1'b0;
         r_run         <= '0;
      end else if (r_collect) begin
         r_run      <= w_run_nxt;
         r_last_bit <= din;
         if (w_run_nxt == REP) begin
            r_health_fail <= 1'b1;
         end
      end
   end

   assign health_fail = r_health_fail;
`else
   assign health_fail = 1'b0;
`endif

   assign collect = r_collect;
   assign samples = r_samples;
   assign ones    = r_ones;
   assign done    = r_done;

endmodule

// File: tb/tb_frotaegis_top.sv
// Randomized bench with a bit-stream reference model and a done-triggered scoreboard.
// Latency: inputs driven 1ns after the rising edge; outputs compared at the falling edge.
// Backpressure: n/a.
module tb_frotaegis_top;
   import fortaegis_pkg::*;

   localparam int N = 256;
`ifdef FORTAEGIS_HEALTH_TEST_EN
   localparam bit HEALTH_ON = 1'b1;
`else
   localparam bit HEALTH_ON = 1'b0;
`endif

   logic              clk350 = 1'b0;
   logic              rst;
   logic              din;
   logic              restart;
   logic              collect;
   logic [SIG_W-1:0]  sig;
   logic [CNT_W-1:0]  samples;
   logic [CNT_W-1:0]  ones;
   logic              done;
   logic              health_fail;

   typedef struct {
      logic [31:0] sig;
      int          samples;
      int          ones;
      bit          hf;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   n_done   = 0;

   always #5 clk350 = ~clk350;

   frotaegis_top dut (
      .clk350      (clk350),
      .rst         (rst),
      .din         (din),
      .restart     (restart),
      .collect     (collect),
      .sig         (sig),
      .samples     (samples),
      .ones        (ones),
      .done        (done),
      .health_fail (health_fail)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding window result.
   always begin
      exp_t e;
      @(negedge clk350);
      if (done === 1'b1) begin
         n_done++;
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
         end else begin
            e = q.pop_front();
            chk("sb_sig",     sig,         e.sig);
            chk("sb_samples", samples,     e.samples);
            chk("sb_ones",    ones,        e.ones);
            chk("sb_hf",      health_fail, e.hf);
            chk("sb_collect", collect,     1'b0);
         end
      end
   end

   task automatic do_restart(input string tag);
      restart = 1'b1;
      @(posedge clk350); #1;
      restart = 1'b0;
      chk({tag, "_collect"}, collect,     1'b1);
      chk({tag, "_sig"},     sig,         SEED);
      chk({tag, "_samples"}, samples,     0);
      chk({tag, "_ones"},    ones,        0);
      chk({tag, "_hf"},      health_fail, 1'b0);
   endtask

   // One window of stimulus. mode 0: zeros, 1: ones, 2: random.
   // stop_at>0 pulls Collect low after that many samples; restart_at pulses restart mid-window.
   task automatic window(input int mode, input int stop_at, input int restart_at,
                         input bit restart_on_done, input string tag);
      logic [31:0] s;
      int          n, n1, run, maxrun;
      bit          b, prev;
      exp_t        e;
      s = SEED; n1 = 0; run = 0; maxrun = 0; prev = 1'b0;
      n = (stop_at > 0) ? stop_at : N;
      for (int i = 0; i < n; i++) begin
         case (mode)
            0:       b = 1'b0;
            1:       b = 1'b1;
            default: b = 1'($urandom_range(0, 1));
         endcase
         din     = b;
         restart = (i == restart_at);
         n1 += int'(b);
         run = (i > 0 && b == prev) ? run + 1 : 1;
         if (run > maxrun) maxrun = run;
         prev = b;
         // Polynomial division step on the message bit stream, MSB first.
         if (s[31] ^ b) s = (s << 1) ^ POLY;
         else           s = s << 1;
         @(posedge clk350); #1;
         restart = 1'b0;
         if (stop_at == 0 && i == n - 2) chk({tag, "_collect_before_end"}, collect, 1'b1);
      end
      e.sig = s; e.samples = n; e.ones = n1; e.hf = HEALTH_ON && (maxrun >= REP_LIMIT);
      q.push_back(e);
      if (stop_at > 0) begin
         force dut.r_collect = 1'b0;
         @(posedge clk350); #1;
         release dut.r_collect;
      end else begin
         chk({tag, "_done_not_early"}, done, 1'b0);
      end
      chk({tag, "_collect_end"}, collect, 1'b0);
      if (restart_on_done) begin
         @(posedge clk350); #1;
         chk({tag, "_done_cycle"}, done, 1'b1);
         do_restart({tag, "_rod"});
      end else begin
         repeat (3) begin
            din = 1'($urandom_range(0, 1));
            @(posedge clk350); #1;
         end
         chk({tag, "_frozen_sig"},     sig,         e.sig);
         chk({tag, "_frozen_samples"}, samples,     e.samples);
         chk({tag, "_frozen_ones"},    ones,        e.ones);
         chk({tag, "_frozen_hf"},      health_fail, e.hf);
         chk({tag, "_done_over"},      done,        1'b0);
      end
      for (int k = 0; k < 10 && q.size() != 0; k++) begin
         @(posedge clk350); #1;
      end
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_done_timeout actual=pending required=drained", tag);
         q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; din = 1'b0; restart = 1'b0;
      repeat (3) @(posedge clk350);
      #1;
      chk("rst_collect", collect,     1'b1);
      chk("rst_sig",     sig,         SEED);
      chk("rst_samples", samples,     0);
      chk("rst_ones",    ones,        0);
      chk("rst_done",    done,        1'b0);
      chk("rst_hf",      health_fail, 1'b0);
      rst = 1'b0;

      window(1, 0, -1, 1'b0, "ones");
      do_restart("r1");
      window(0, 0, -1, 1'b0, "zeros");
      do_restart("r2");
      window(2, 100, -1, 1'b0, "force");
      do_restart("r3");
      window(2, 0, 30, 1'b1, "midrst");

      // Reset in the middle of a window aborts it without a done pulse.
      for (int i = 0; i < 50; i++) begin
         din = 1'($urandom_range(0, 1));
         @(posedge clk350); #1;
      end
      chk("abort_samples_pre", samples, 50);
      rst = 1'b1;
      @(posedge clk350); #1;
      rst = 1'b0;
      chk("abort_collect", collect, 1'b1);
      chk("abort_samples", samples, 0);
      chk("abort_ones",    ones,    0);
      chk("abort_sig",     sig,     SEED);
      chk("abort_done",    done,    1'b0);
      window(2, 0, -1, 1'b0, "final");

      chk("done_count", n_done, 5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
